// File: rtl/wb_uart_pkg.sv
`default_nettype none
// ============================================================================
// Module : wb_uart_pkg
// Brief  : Shared register map, STATUS bit positions and FSM encodings for the
//          Wishbone UART slaves.
// Rev    : 1.0
// ============================================================================
package wb_uart_pkg;

    localparam logic [31:0] REG_DATA   = 32'h0000_0000;
    localparam logic [31:0] REG_STATUS = 32'h0000_0004;

    localparam int unsigned STAT_BUSY      = 0;
    localparam int unsigned STAT_EMPTY     = 1;
    localparam int unsigned STAT_FULL      = 2;
    localparam int unsigned STAT_OVERFLOW  = 3;
    localparam int unsigned STAT_LEVEL_LSB = 4;
    localparam int unsigned STAT_LEVEL_W   = 4;

    typedef enum logic [0:0] {
        BUS_IDLE = 1'b0,
        BUS_ACK  = 1'b1
    } bus_state_t;

    typedef enum logic [2:0] {
        TX_IDLE   = 3'd0,
        TX_START  = 3'd1,
        TX_DATA   = 3'd2,
        TX_PARITY = 3'd3,
        TX_STOP   = 3'd4
    } tx_state_t;

endpackage
`default_nettype wire

// File: rtl/uart_tx_serializer.sv
`default_nettype none
// ============================================================================
// Module : uart_tx_serializer
// Brief  : Baud counter, TX FSM and shifter; valid/ready byte in, serial out.
//          UART_TX_PARITY_EN adds an even-parity bit between data and stop.
// Rev    : 1.0
// ============================================================================
module uart_tx_serializer
    import wb_uart_pkg::*;
#(
    parameter int unsigned BAUD_DIV = 234
) (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic       in_valid,
    output logic       in_ready,
    input  logic [7:0] in_data,
    output logic       uart_tx_o,
    output logic       busy
);

    localparam int unsigned        C_CNT_W     = (BAUD_DIV > 1) ? $clog2(BAUD_DIV) : 1;
    localparam logic [C_CNT_W-1:0] C_BAUD_LAST = C_CNT_W'(BAUD_DIV - 1);

    tx_state_t          r_state;
    logic [C_CNT_W-1:0] r_baud;
    logic [2:0]         r_bit;
    logic [7:0]         r_shift;
    logic               r_tx;
`ifdef UART_TX_PARITY_EN
    logic               r_parity;
`endif
    logic               w_baud_end;

    assign w_baud_end = (r_baud == C_BAUD_LAST);
    // Accepting at the last STOP cycle lets the next START follow with no idle gap.
    assign in_ready   = (r_state == TX_IDLE) || ((r_state == TX_STOP) && w_baud_end);
    assign uart_tx_o  = r_tx;
    assign busy       = (r_state != TX_IDLE);

    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            r_state  <= TX_IDLE;
            r_baud   <= '0;
            r_bit    <= '0;
            r_shift  <= '0;
            r_tx     <= 1'b1;
`ifdef UART_TX_PARITY_EN
            r_parity <= 1'b0;
`endif
        end else begin
            r_baud <= w_baud_end ? '0 : r_baud + 1'b1;
            case (r_state)
                TX_IDLE: begin
                    r_baud <= '0;
                    if (in_valid) begin
                        r_shift  <= in_data;
`ifdef UART_TX_PARITY_EN
                        r_parity <= ^in_data;
`endif
                        r_tx     <= 1'b0;
                        r_state  <= TX_START;
                    end
                end
                TX_START: begin
                    if (w_baud_end) begin
                        r_tx    <= r_shift[0];
                        r_shift <= {1'b0, r_shift[7:1]};
                        r_bit   <= '0;
                        r_state <= TX_DATA;
                    end
                end
                TX_DATA: begin
                    if (w_baud_end) begin
                        if (r_bit == 3'd7) begin
`ifdef UART_TX_PARITY_EN
                            r_tx    <= r_parity;
                            r_state <= TX_PARITY;
`else
                            r_tx    <= 1'b1;
                            r_state <= TX_STOP;
`endif
                        end else begin
                            r_tx    <= r_shift[0];
                            r_shift <= {1'b0, r_shift[7:1]};
                            r_bit   <= r_bit + 3'd1;
                        end
                    end
                end
`ifdef UART_TX_PARITY_EN
                TX_PARITY: begin
                    if (w_baud_end) begin
                        r_tx    <= 1'b1;
                        r_state <= TX_STOP;
                    end
                end
`endif
                TX_STOP: begin
                    if (w_baud_end) begin
                        if (in_valid) begin
                            r_shift  <= in_data;
`ifdef UART_TX_PARITY_EN
                            r_parity <= ^in_data;
`endif
                            r_tx     <= 1'b0;
                            r_state  <= TX_START;
                        end else begin
                            r_tx     <= 1'b1;
                            r_state  <= TX_IDLE;
                        end
                    end
                end
                default: begin
                    r_tx    <= 1'b1;
                    r_state <= TX_IDLE;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: rtl/wishbone_uart_tx_slave.sv
`default_nettype none
// ============================================================================
// Module : wishbone_uart_tx_slave
// Brief  : Wishbone classic slave: byte FIFO feeding an 8N1 UART transmitter.
//          Define UART_TX_PARITY_EN for an 8E1 frame.
// Rev    : 1.0
// ============================================================================
module wishbone_uart_tx_slave
    import wb_uart_pkg::*;
#(
    parameter int unsigned CLK_FREQ_HZ = 27000000,
    parameter int unsigned BAUD_RATE   = 115200,
    parameter int unsigned FIFO_DEPTH  = 4
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic [31:0] addr_i,
    input  logic        we_i,
    input  logic [31:0] data_i,
    input  logic        cyc_i,
    input  logic        stb_i,
    output logic [31:0] data_o,
    output logic        ack_o,
    output logic        uart_tx_o,
    output logic        tx_busy_o
);

    localparam int unsigned    BAUD_DIV = CLK_FREQ_HZ / BAUD_RATE;
    localparam int unsigned    C_AW     = $clog2(FIFO_DEPTH);
    localparam int unsigned    C_PW     = C_AW + 1;
    localparam logic [C_AW:0]  C_DEPTH  = C_PW'(FIFO_DEPTH);

    logic [7:0]    r_mem [FIFO_DEPTH];
    logic [C_AW:0] r_wr_ptr;
    logic [C_AW:0] r_rd_ptr;
    bus_state_t    r_bus_state;
    logic          r_ack;
    logic [31:0]   r_data;
    logic          r_overflow;
    logic          r_busy;

    logic [C_AW:0] w_level;
    logic          w_empty;
    logic          w_full;
    logic          w_req;
    logic          w_is_status;
    logic          w_push;
    logic          w_push_ok;
    logic          w_pop;
    logic          w_ser_ready;
    logic          w_ser_busy;
    logic [31:0]   w_status;
    logic          w_unused;

    assign w_unused    = ^{addr_i[31:3], addr_i[1:0], data_i[31:8]};
    assign w_req       = cyc_i & stb_i;
    assign w_is_status = (addr_i[2] == REG_STATUS[2]);
    assign w_level     = r_wr_ptr - r_rd_ptr;
    assign w_empty     = (w_level == '0);
    assign w_full      = (w_level == C_DEPTH);
    assign w_pop       = w_ser_ready & ~w_empty;
    assign w_push      = (r_bus_state == BUS_IDLE) & w_req & we_i & ~w_is_status;
    // A pop in the same cycle frees the slot a full-FIFO push lands in.
    assign w_push_ok   = w_push & (~w_full | w_pop);

    assign data_o    = r_data;
    assign ack_o     = r_ack;
    assign tx_busy_o = r_busy;

    always_comb begin
        w_status                                  = '0;
        w_status[STAT_LEVEL_LSB +: STAT_LEVEL_W]  = STAT_LEVEL_W'(w_level);
        w_status[STAT_OVERFLOW]                   = r_overflow;
        w_status[STAT_FULL]                       = w_full;
        w_status[STAT_EMPTY]                      = w_empty;
        w_status[STAT_BUSY]                       = r_busy;
    end

    always_ff @(posedge clk_i) begin
        if (w_push_ok) begin
            r_mem[r_wr_ptr[C_AW-1:0]] <= data_i[7:0];
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            r_wr_ptr    <= '0;
            r_rd_ptr    <= '0;
            r_bus_state <= BUS_IDLE;
            r_ack       <= 1'b0;
            r_data      <= '0;
            r_overflow  <= 1'b0;
            r_busy      <= 1'b0;
        end else begin
            if (w_push_ok) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_pop)     r_rd_ptr <= r_rd_ptr + 1'b1;
            r_busy <= ~w_empty | w_ser_busy;
            case (r_bus_state)
                BUS_IDLE: begin
                    if (w_req) begin
                        r_bus_state <= BUS_ACK;
                        r_ack       <= 1'b1;
                        r_data      <= (!we_i && w_is_status) ? w_status : '0;
                        if (w_push && !w_push_ok) r_overflow <= 1'b1;
                        if (!we_i && w_is_status) r_overflow <= 1'b0;
                    end
                end
                BUS_ACK: begin
                    if (!w_req) begin
                        r_bus_state <= BUS_IDLE;
                        r_ack       <= 1'b0;
                        r_data      <= '0;
                    end
                end
                default: begin
                    r_bus_state <= BUS_IDLE;
                    r_ack       <= 1'b0;
                    r_data      <= '0;
                end
            endcase
        end
    end

    uart_tx_serializer #(
        .BAUD_DIV (BAUD_DIV)
    ) u_serializer (
        .clk_i     (clk_i),
        .rst_i     (rst_i),
        .in_valid  (~w_empty),
        .in_ready  (w_ser_ready),
        .in_data   (r_mem[r_rd_ptr[C_AW-1:0]]),
        .uart_tx_o (uart_tx_o),
        .busy      (w_ser_busy)
    );

endmodule
`default_nettype wire

// File: tb/tb_wishbone_uart_tx_slave.sv
`default_nettype none
// ============================================================================
// Module : tb_wishbone_uart_tx_slave
// Brief  : Scoreboard bench: bus and UART monitors check against queued expectations.
// Rev    : 1.0
// ============================================================================
module tb_wishbone_uart_tx_slave;

    localparam int BAUD  = 27000000 / 115200;
    localparam int HALF  = BAUD / 2;
`ifdef UART_TX_PARITY_EN
    localparam int NB    = 11;
`else
    localparam int NB    = 10;
`endif
    localparam int FRAME = NB * BAUD;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] addr;
    logic        we;
    logic [31:0] wdat;
    logic        cyc;
    logic        stb;
    logic [31:0] data_o;
    logic        ack_o;
    logic        uart_tx;
    logic        tx_busy;

    int          total = 0;
    int          bad   = 0;
    int          cyc_cnt = 0;
    logic [7:0]  uart_q[$];
    logic [31:0] bus_q[$];
    int          start_times[$];

    wishbone_uart_tx_slave dut (
        .clk_i     (clk),
        .rst_i     (rst_n),
        .addr_i    (addr),
        .we_i      (we),
        .data_i    (wdat),
        .cyc_i     (cyc),
        .stb_i     (stb),
        .data_o    (data_o),
        .ack_o     (ack_o),
        .uart_tx_o (uart_tx),
        .tx_busy_o (tx_busy)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: actual=0x%0h required=0x%0h", name, act, exp);
        end
    endtask

    function automatic logic [NB-1:0] make_frame(input logic [7:0] b);
`ifdef UART_TX_PARITY_EN
        return {1'b1, ^b, b, 1'b0};
`else
        return {1'b1, b, 1'b0};
`endif
    endfunction

    // One bus transfer; expected read data goes to the scoreboard before the request.
    task automatic wb_xfer(input string nm, input logic [31:0] a, input logic w,
                           input logic [31:0] d, input int hold, input logic [31:0] exp_rd);
        int n;
        bus_q.push_back(exp_rd);
        addr = a; we = w; wdat = d; cyc = 1'b1; stb = 1'b1;
        n = 0;
        do begin
            @(posedge clk); #1; n++;
        end while (!ack_o && n < 8);
        check({nm, "_ack_latency"}, n, 1);
        if (hold > 0) begin
            repeat (hold) begin @(posedge clk); #1; end
            check({nm, "_ack_held"}, {31'b0, ack_o}, 1);
        end
        cyc = 1'b0; stb = 1'b0; we = 1'b0;
        @(posedge clk); #1;
        check({nm, "_ack_release"}, {31'b0, ack_o}, 0);
    endtask

    task automatic wait_idle(input int limit);
        int n;
        n = 0;
        while (tx_busy !== 1'b0 && n < limit) begin @(posedge clk); #1; n++; end
        check("tx_idle_timeout", {31'b0, tx_busy}, 0);
    endtask

    task automatic check_gaps(input string nm, input int frames);
        check({nm, "_frame_count"}, start_times.size(), frames);
        for (int i = 1; i < start_times.size(); i++)
            check({nm, "_frame_gap"}, start_times[i] - start_times[i-1], FRAME);
    endtask

    initial begin : bus_monitor
        logic        ack_prev;
        logic [31:0] e;
        ack_prev = 1'b0;
        forever begin
            @(negedge clk);
            if (ack_o && !ack_prev) begin
                if (bus_q.size() == 0) begin
                    total++; bad++;
                    $display("FAIL bus_rdata: unexpected ack actual=0x%0h required=none", data_o);
                end else begin
                    e = bus_q.pop_front();
                    check("bus_rdata", data_o, e);
                end
            end else if (!ack_o && ack_prev) begin
                check("bus_rdata_idle", data_o, 32'h0);
            end
            ack_prev = ack_o;
        end
    end

    initial begin : uart_monitor
        logic          line_prev;
        logic          aborted;
        logic [NB-1:0] fr;
        logic [7:0]    b;
        line_prev = 1'b1;
        forever begin
            @(negedge clk);
            if (rst_n && line_prev && !uart_tx) begin
                start_times.push_back(cyc_cnt);
                aborted = 1'b0;
                fr = '0;
                for (int k = 0; k < NB && !aborted; k++) begin
                    for (int w = 0; w < ((k == 0) ? HALF : BAUD) && !aborted; w++) begin
                        @(negedge clk);
                        if (!rst_n) aborted = 1'b1;
                    end
                    fr[k] = uart_tx;
                end
                if (!aborted) begin
                    if (uart_q.size() == 0) begin
                        total++; bad++;
                        $display("FAIL uart_frame: unexpected frame actual=0x%0h required=none", fr);
                    end else begin
                        b = uart_q.pop_front();
                        check("uart_frame", 32'(fr), 32'(make_frame(b)));
                    end
                end
            end
            line_prev = uart_tx;
        end
    end

    initial begin : watchdog
        #3000000;
        $display("FAIL watchdog: actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin : stimulus
        logic quiet_bad;
        rst_n = 1'b0; cyc = 1'b0; stb = 1'b0; we = 1'b0; addr = '0; wdat = '0;
        repeat (3) @(posedge clk);
        #1;
        check("reset_uart_tx", {31'b0, uart_tx}, 1);
        check("reset_ack",     {31'b0, ack_o},   0);
        check("reset_busy",    {31'b0, tx_busy}, 0);
        check("reset_data_o",  data_o,           0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        // Reset state, DATA read, STATUS write
        wb_xfer("status_reset", 32'h4, 1'b0, 32'h0,  0, 32'h02);
        wb_xfer("data_read",    32'h0, 1'b0, 32'h0,  0, 32'h00);
        wb_xfer("status_write", 32'h4, 1'b1, 32'hFF, 0, 32'h00);
        wb_xfer("status_after", 32'h4, 1'b0, 32'h0,  0, 32'h02);

        // Single frame 0x55
        start_times.delete();
        uart_q.push_back(8'h55);
        wb_xfer("wr_55", 32'h0, 1'b1, 32'hFFFF_FF55, 0, 32'h0);
        wait_idle(20000);
        check_gaps("single", 1);
        wb_xfer("status_idle", 32'h4, 1'b0, 32'h0, 0, 32'h02);

        // Burst: first byte pops at once, four fill the FIFO, the sixth overflows
        start_times.delete();
        uart_q.push_back(8'hA1); uart_q.push_back(8'hB2); uart_q.push_back(8'hC3);
        uart_q.push_back(8'hD4); uart_q.push_back(8'hE5);
        wb_xfer("wr_a1", 32'h0, 1'b1, 32'hA1, 0, 32'h0);
        wb_xfer("wr_b2", 32'h0, 1'b1, 32'hB2, 0, 32'h0);
        wb_xfer("wr_c3", 32'h0, 1'b1, 32'hC3, 0, 32'h0);
        wb_xfer("wr_d4", 32'h0, 1'b1, 32'hD4, 0, 32'h0);
        wb_xfer("wr_e5", 32'h0, 1'b1, 32'hE5, 0, 32'h0);
        wb_xfer("wr_f6", 32'h0, 1'b1, 32'hF6, 0, 32'h0);
        wb_xfer("status_ovf",   32'h4, 1'b0, 32'h0, 0, 32'h4D);
        wb_xfer("status_clear", 32'h4, 1'b0, 32'h0, 0, 32'h45);
        wait_idle(20000);
        check_gaps("burst", 5);
        wb_xfer("status_drain", 32'h4, 1'b0, 32'h0, 0, 32'h02);

        // Held strobe enqueues exactly one byte behind a frame in flight
        start_times.delete();
        uart_q.push_back(8'h11); uart_q.push_back(8'h3C);
        wb_xfer("wr_11",   32'h0, 1'b1, 32'h11, 0, 32'h0);
        wb_xfer("wr_held", 32'h0, 1'b1, 32'h3C, 9, 32'h0);
        wb_xfer("status_level1", 32'h4, 1'b0, 32'h0, 0, 32'h11);
        wait_idle(20000);
        check_gaps("held", 2);

        // Reset mid-DATA with one byte still queued
        wb_xfer("wr_0f", 32'h0, 1'b1, 32'h0F, 0, 32'h0);
        wb_xfer("wr_99", 32'h0, 1'b1, 32'h99, 0, 32'h0);
        repeat (1000) @(posedge clk);
        #1;
        rst_n = 1'b0;
        @(posedge clk); #1;
        check("abort_uart_tx", {31'b0, uart_tx}, 1);
        check("abort_busy",    {31'b0, tx_busy}, 0);
        rst_n = 1'b1;
        @(posedge clk); #1;
        wb_xfer("status_abort", 32'h4, 1'b0, 32'h0, 0, 32'h02);
        quiet_bad = 1'b0;
        repeat (3000) begin
            @(posedge clk); #1;
            if (uart_tx !== 1'b1 || tx_busy !== 1'b0) quiet_bad = 1'b1;
        end
        check("abort_quiet", {31'b0, quiet_bad}, 0);

        check("uart_q_drained", uart_q.size(), 0);
        check("bus_q_drained",  bus_q.size(),  0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
